// File: rtl/fifo_rd_prefetch.sv
// fifo_rd_prefetch
//   First-word-fall-through prefetch stage on the read side of a FIFO. Pops
//   words from the read-pointer stage into a 3-entry in-order buffer and
//   presents the head word downstream with a valid/ready handshake.
//
// Ports
//   rclk        read-domain clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   empty       registered FIFO empty flag
//   rinc        pop request; a pop is accepted when rinc=1 and empty=0
//   rdata       FIFO read data, valid in the cycle after an accepted pop
//   dout        head-of-buffer word
//   dout_valid  dout holds a valid word
//   dout_ready  downstream accepts dout this cycle
//   buf_count   words currently held in the buffer (0..3)
module fifo_rd_prefetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  empty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [1:0]            buf_count
);

    generate
        if (ADDR_WIDTH < 1) begin : g_addr_chk
            $error("fifo_rd_prefetch: ADDR_WIDTH must be at least 1");
        end
    endgenerate

    logic [2:0][DATA_WIDTH-1:0] mem;
    logic [1:0]                 head;
    logic [1:0]                 tail;
    logic [1:0]                 count;
    logic                       inflight;   // a pop was accepted last edge; rdata is live now
    logic [2:0]                 occupancy;
    logic                       xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for the in-flight word so the buffer can never overflow.
    // rst_n gating keeps rinc low during reset even though empty may be low.
    assign occupancy  = {1'b0, count} + {2'b00, inflight};
    assign rinc       = rst_n & ~empty & (occupancy < 3'd3);
    assign dout_valid = (count != 2'd0);
    assign xfer       = dout_valid & dout_ready;
    assign buf_count  = count;

    always_comb begin
        dout = mem[0];
        case (head)
            2'd1:    dout = mem[1];
            2'd2:    dout = mem[2];
            default: dout = mem[0];
        endcase
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            head     <= 2'd0;
            tail     <= 2'd0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            // rinc already implies ~empty, so rinc alone marks an accepted pop
            inflight <= rinc;

            // Capture never lands on the head entry while it is valid: the
            // pop that produced it was only issued with a free slot reserved.
            if (inflight) begin
                for (int i = 0; i < 3; i++) begin
                    if (tail == 2'(i)) mem[i] <= rdata;
                end
                tail <= ptr_inc(tail);
            end

            if (xfer) head <= ptr_inc(head);

            case ({inflight, xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
